// File: rtl/entropy_subsys_sync_fifo_if.sv
// entropy_subsys_sync_fifo_if: producer/consumer handshake, status and error bundle of the entropy FIFO
interface entropy_subsys_sync_fifo_if #(
  parameter int Width = 32,
  parameter int Depth = 4
);
  localparam int DepthW = $clog2(Depth + 1);
  logic              wvalid_i;
  logic [Width-1:0]  wdata_i;
  logic              wready_o;
  logic              full_o;
  logic              rvalid_o;
  logic              rready_i;
  logic [Width-1:0]  rdata_o;
  logic [DepthW-1:0] depth_o;
  logic [2:0]        err_pulse_o;
  logic [2:0]        err_sticky_o;
  modport master (
    output wvalid_i, wdata_i, rready_i,
    input  wready_o, full_o, rvalid_o, rdata_o, depth_o, err_pulse_o, err_sticky_o
  );
  modport slave (
    input  wvalid_i, wdata_i, rready_i,
    output wready_o, full_o, rvalid_o, rdata_o, depth_o, err_pulse_o, err_sticky_o
  );
endinterface

// File: rtl/entropy_subsys_sync_fifo.sv
// entropy_subsys_sync_fifo: FWFT sync FIFO with read/write/state exception pulses and sticky status
module entropy_subsys_sync_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input logic clk_i,
  input logic rst_i,
  input logic clr_i,
  entropy_subsys_sync_fifo_if.slave bus
);
  localparam int DepthW = $clog2(Depth + 1);
  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] Last = PtrW'(Depth - 1);
  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic              wph_q, wph_d, rph_q, rph_d;
  logic [DepthW-1:0] cnt_q, cnt_d, ptr_occ;
  logic [2:0]        hist_q, hist_d, sticky_q, sticky_d, cond;
  logic              empty, full, we, re;
  always_comb begin
    empty   = (wptr_q == rptr_q) && (wph_q == rph_q);
    full    = cnt_q == DepthW'(Depth);
    we      = bus.wvalid_i && !full && !clr_i;
    re      = bus.rready_i && !empty && !clr_i;
    wptr_d  = clr_i ? '0 : we ? ((wptr_q == Last) ? '0 : wptr_q + PtrW'(1)) : wptr_q;
    rptr_d  = clr_i ? '0 : re ? ((rptr_q == Last) ? '0 : rptr_q + PtrW'(1)) : rptr_q;
    wph_d   = !clr_i && (wph_q ^ (we && wptr_q == Last));
    rph_d   = !clr_i && (rph_q ^ (re && rptr_q == Last));
    cnt_d   = clr_i ? '0 : cnt_q + DepthW'(we) - DepthW'(re);
    // occupancy rebuilt from the pointers, cross-checked against the counter
    ptr_occ = (wph_q == rph_q) ? DepthW'(wptr_q) - DepthW'(rptr_q)
                               : DepthW'(Depth) + DepthW'(wptr_q) - DepthW'(rptr_q);
    cond    = {(full && empty) || (cnt_q != ptr_occ), bus.wvalid_i && full, bus.rready_i && empty};
    hist_d  = clr_i ? '0 : cond;
    sticky_d = clr_i ? '0 : sticky_q | (cond & ~hist_q);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      wph_q    <= 1'b0;
      rph_q    <= 1'b0;
      cnt_q    <= '0;
      hist_q   <= '0;
      sticky_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wph_q    <= wph_d;
      rph_q    <= rph_d;
      cnt_q    <= cnt_d;
      hist_q   <= hist_d;
      sticky_q <= sticky_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (we) mem_q[wptr_q] <= bus.wdata_i;
  end
  assign bus.full_o       = full;
  assign bus.wready_o     = !full;
  assign bus.rvalid_o     = !empty;
  assign bus.rdata_o      = empty ? '0 : mem_q[rptr_q];
  assign bus.depth_o      = cnt_q;
  assign bus.err_pulse_o  = cond & ~hist_q;
  assign bus.err_sticky_o = sticky_q;
endmodule

// File: doc/entropy_subsys_sync_fifo.md
Name: entropy_subsys_sync_fifo

Overview:
- Synchronous first-word-fall-through FIFO for the entropy complex (entropy_src, CSRNG, EDN datapaths).
- Exposes the valid/ready/full handshake signals that the team's FIFO exception monitor observes.
- Detects read, write and state exceptions in hardware and reports them as one-cycle pulses and sticky status bits, so the IP can raise its own error and alert.
- Sits between a producer stage and a consumer stage inside each IP.

Parameters:
- Width, 32, data width in bits (>=1).
- Depth, 4, number of entries (>=2, need not be a power of two).
- DepthW, $clog2(Depth+1), width of the occupancy output (derived, not overridable).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- clr_i  in  1  synchronous flush of contents and sticky errors.
- wvalid_i  in  1  write request.
- wdata_i  in  Width  write data.
- wready_o  out  1  space available (= !full_o).
- full_o  out  1  occupancy == Depth.
- rvalid_o  out  1  FIFO non-empty; rdata_o valid.
- rready_i  in  1  read request.
- rdata_o  out  Width  head entry.
- depth_o  out  DepthW  current occupancy 0..Depth.
- err_pulse_o  out  3  one-cycle error pulses: [0] read, [1] write, [2] state.
- err_sticky_o  out  3  sticky error status, same bit order.

Behaviour:
- Reset (async assert, sync release): pointers, phase bits, count, error history and sticky bits all 0.
- Outputs after reset: rvalid_o=0, full_o=0, wready_o=1, depth_o=0, err_pulse_o=0, err_sticky_o=0, rdata_o=0.
- Memory contents are not reset. rdata_o is forced to 0 while empty.
- Storage: Depth x Width register array; write pointer and read pointer each 0..Depth-1, each with a phase bit.
- Pointer wrap: Depth-1 -> 0, phase bit toggles on wrap.
- Empty: pointers equal and phases equal. Full: pointers equal and phases differ.
- Separate occupancy counter: +1 on write only, -1 on read only, unchanged when both or neither occur. depth_o is the counter.
- full_o = (count == Depth). rvalid_o = pointer-based non-empty.
- Write accepted when wvalid_i && !full_o, evaluated on current-cycle state. A write while full is dropped even if a read happens the same cycle.
- Read accepted when rready_i && rvalid_o. The head advances next cycle.
- FWFT: a write into an empty FIFO gives rvalid_o=1 and rdata_o=wdata the next cycle (latency 1).
- Simultaneous read and write when non-empty and non-full: both accepted, depth unchanged.
- Error conditions (combinational, current cycle):
  - write_err = wvalid_i && full_o.
  - read_err = rready_i && !rvalid_o.
  - state_err = full_o && !rvalid_o, or count disagreeing with pointer-derived occupancy. Unreachable in correct operation; a fault/glitch detector.
- Error history registered each cycle.
- err_pulse_o[k] = cond_k && !cond_k_q (combinational rising edge). A held condition gives exactly one pulse; it re-pulses after the condition deasserts for >=1 cycle.
- err_sticky_o[k] sets on the cycle after err_pulse_o[k]. It holds until clr_i or reset.
- clr_i has priority over same-cycle read and write:
  - next cycle: empty, depth 0, sticky 0, history 0;
  - no write or read is accepted that cycle;
  - err_pulse_o still reflects current-cycle conditions combinationally.
- Reset mid-operation: immediate return to reset values, no partial pointer update.

Test Plan:
1. Depth=4. Write 0xA0..0xA3 back-to-back, no reads -> depth_o 1,2,3,4. full_o=1 and wready_o=0 after the 4th write. Then read 4 -> rdata 0xA0..0xA3 in order, rvalid_o=0 after the last read.
2. Full FIFO with wvalid_i held 3 cycles -> err_pulse_o[1]=1 for the first cycle only, err_sticky_o[1]=1 from the next cycle, contents unchanged, depth_o stays 4.
3. Empty FIFO, rready_i=1 for 2 cycles while wvalid_i=1 with 0x55 in cycle 1 -> err_pulse_o[0] pulses once in cycle 1. In cycle 2, rvalid_o=1 with rdata_o=0x55, the read is accepted, and depth_o returns to 0 in cycle 3.
4. Depth=3 (non-power-of-two). 10 cycles of simultaneous read and write at depth 2 -> data order preserved across wraps, depth_o constant at 2, no error pulses.
5. Sticky write error set, FIFO holding 2 entries. Pulse clr_i together with wvalid_i and rready_i -> next cycle depth_o=0, rvalid_o=0, err_sticky_o=0, new data not stored.
6. Force the counter to Depth while empty -> err_pulse_o[2]=1 the same cycle, err_sticky_o[2]=1 the next cycle. Assert rst_i mid-burst -> all outputs at reset values immediately.
